// File: rtl/dmem_access_unit_pkg.sv
// rtl/dmem_access_unit_pkg.sv - shared FSM encodings and default constants for the data-memory access unit
package dmem_access_unit_pkg;

    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } dmem_state_e;

endpackage

// File: rtl/dmem_timeout_counter.sv
// rtl/dmem_timeout_counter.sv - watchdog counting cycles spent in an outstanding bus access
module dmem_timeout_counter #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic active_i,
    output logic expired_o
);

    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired_o = active_i && (cnt_q == CNT_W'(LIMIT - 1));

    // Restart on access entry, then count every outstanding cycle; hold once expired.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (active_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - MEM-stage load/store bridge to a valid/ready data bus; optional watchdog under DMEM_TIMEOUT_EN
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_read_MEM,
    input  logic                    mem_write_MEM,
    input  logic [ADDR_WIDTH-1:0]   addr_MEM,
    input  logic [DATA_WIDTH-1:0]   wdata_MEM,
    input  logic [DATA_WIDTH/8-1:0] byte_en_MEM,
    output logic                    data_mem_hazard,
    output logic [DATA_WIDTH-1:0]   rdata_MEM,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic                    req_we,
    output logic [ADDR_WIDTH-1:0]   req_addr,
    output logic [DATA_WIDTH-1:0]   req_wdata,
    output logic [DATA_WIDTH/8-1:0] req_be,
    input  logic                    rsp_valid,
    input  logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    dmem_err
);

    localparam int BE_W = DATA_WIDTH / 8;

    dmem_state_e state_q;
    dmem_state_e state_d;

    logic                  req_we_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] req_wdata_q;
    logic [BE_W-1:0]       req_be_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic access_req;
    logic start_access;
    logic timeout_expired;
    logic timeout_hit;

    assign access_req   = mem_read_MEM | mem_write_MEM;
    assign start_access = (state_q == ST_IDLE) && access_req;

`ifdef DMEM_TIMEOUT_EN
    logic in_access;
    assign in_access = (state_q == ST_REQ) || (state_q == ST_WAIT_RSP);

    dmem_timeout_counter #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (start_access),
        .active_i (in_access),
        .expired_o(timeout_expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_expired    = 1'b0;
`endif

    // A normal handshake in the same cycle wins over the watchdog.
    assign timeout_hit = timeout_expired &&
                         (((state_q == ST_REQ) && !req_ready) ||
                          ((state_q == ST_WAIT_RSP) && !rsp_valid));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: DONE always returns to IDLE so a held request is not re-issued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (access_req) state_d = ST_REQ;
            ST_REQ:      if (req_ready) state_d = ST_WAIT_RSP;
                         else if (timeout_hit) state_d = ST_DONE;
            ST_WAIT_RSP: if (rsp_valid || timeout_hit) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; in IDLE the stall is raised combinationally by the request.
    always_comb begin
        req_valid       = 1'b0;
        data_mem_hazard = 1'b0;
        case (state_q)
            ST_IDLE:     data_mem_hazard = access_req;
            ST_REQ: begin
                req_valid       = 1'b1;
                data_mem_hazard = 1'b1;
            end
            ST_WAIT_RSP: data_mem_hazard = 1'b1;
            default: begin
                req_valid       = 1'b0;
                data_mem_hazard = 1'b0;
            end
        endcase
    end

    // Latch the request fields at access start; capture read data or the timeout zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            if (start_access) begin
                req_we_q    <= mem_write_MEM;
                req_addr_q  <= addr_MEM;
                req_wdata_q <= wdata_MEM;
                req_be_q    <= byte_en_MEM;
            end
            if ((state_q == ST_WAIT_RSP) && rsp_valid && !req_we_q) begin
                rdata_q <= rsp_rdata;
            end else if (timeout_hit && !req_we_q) begin
                rdata_q <= '0;
            end
            err_q <= timeout_hit;
        end
    end

    assign req_we    = req_we_q;
    assign req_addr  = req_addr_q;
    assign req_wdata = req_wdata_q;
    assign req_be    = req_be_q;
    assign rdata_MEM = rdata_q;
    assign dmem_err  = err_q;

endmodule
